regfile_scoreboard: RTL and testbench

- Parametrised integer register file with 2 combinational read ports and 1 write-back port.
- Adds a per-register busy scoreboard for in-flight destinations, hazard stall generation and a sticky write-back protocol error flag.
- Sits between decode/issue and the write-back stage of the RV32I core.
- Replaces the fixed 32x32 register file.

---
 rtl/regfile_scoreboard.sv | 124 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file (2 read, 1 write-back) with per-register busy scoreboard,
// hazard stall and sticky write-back error. Optional same-cycle bypass: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic            issue_rd_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [NREG-1:0] busy_vec,
  output logic            wb_err
);

  localparam bit ZeroEn = (ZERO_REG != 0);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_eff;
  logic            wb_err_q;
  logic            wb_err_d;
  logic            wb_hit;
  logic            issue_set;
  logic            rs1_hz;
  logic            rs2_hz;
  logic            rd_hz;
  logic            stall_c;

  // A write-back to the hardwired zero register is a complete no-op.
  assign wb_hit = wb_valid & ~(ZeroEn & (wb_rd == '0));

  // Effective busy: a register being written back this cycle counts as free with bypass.
  always_comb begin
    busy_eff = busy_q;
`ifdef REGFILE_BYPASS_EN
    if (wb_hit) begin
      busy_eff[wb_rd] = 1'b0;
    end
`endif
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_hit && (wb_rd == addr)) begin
      val = wb_data;
    end
`endif
    if (ZeroEn && (addr == '0)) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

  // RAW on either source or WAW on the destination holds issue.
  always_comb begin
    rs1_hz  = rs1_used & busy_eff[rs1_addr];
    rs2_hz  = rs2_used & busy_eff[rs2_addr];
    rd_hz   = issue_rd_en & busy_eff[issue_rd];
    stall_c = issue_valid & (rs1_hz | rs2_hz | rd_hz);
  end

  assign issue_set = issue_valid & ~stall_c & issue_rd_en & ~(ZeroEn & (issue_rd == '0));

  // Scoreboard next state; an issue set is applied after the wb clear so set wins.
  always_comb begin
    busy_d   = busy_q;
    wb_err_d = wb_err_q;
    if (wb_hit) begin
      if (!busy_q[wb_rd]) begin
        wb_err_d = 1'b1;
      end
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      wb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      wb_err_q <= wb_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_hit) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign stall    = stall_c;
  assign busy_vec = busy_q;
  assign wb_err   = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios, a randomized run
// against a behavioural model, and a 64-bit/16-entry/no-zero-register instance.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
  logic        rs1_used, rs2_used, issue_valid, issue_rd_en, wb_valid;
  logic [31:0] rs1_data, rs2_data, wb_data, busy_vec;
  logic        stall, wb_err;

  logic [3:0]  b_rs1_addr, b_rs2_addr, b_issue_rd, b_wb_rd;
  logic        b_rs1_used, b_rs2_used, b_issue_valid, b_issue_rd_en, b_wb_valid;
  logic [63:0] b_rs1_data, b_rs2_data, b_wb_data;
  logic [15:0] b_busy_vec;
  logic        b_stall, b_wb_err;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard dut_a (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy_vec(busy_vec), .wb_err(wb_err)
  );

  regfile_scoreboard #(.XLEN(64), .NREG(16), .AW(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst(rst),
    .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr), .rs1_used(b_rs1_used), .rs2_used(b_rs2_used),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .issue_valid(b_issue_valid), .issue_rd_en(b_issue_rd_en), .issue_rd(b_issue_rd), .stall(b_stall),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .busy_vec(b_busy_vec), .wb_err(b_wb_err)
  );

  // Reference model state for the randomized run on dut_a.
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;
  logic        m_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic idle_b();
    b_rs1_addr = '0; b_rs2_addr = '0; b_rs1_used = 1'b0; b_rs2_used = 1'b0;
    b_issue_valid = 1'b0; b_issue_rd_en = 1'b0; b_issue_rd = '0;
    b_wb_valid = 1'b0; b_wb_rd = '0; b_wb_data = '0;
  endtask

  task automatic test_reset();
    idle_a();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      checks++;
      if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr %0d got %h/%h exp 0/0", i, rs1_data, rs2_data);
      end
    end
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
    checks++;
    if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", wb_err); end
    tick();
    rst = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_wb_same got %h exp 0", rs1_data); end
    tick();
    idle_a();
    #1;
    checks++;
    if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_after_wb got %h exp 0", rs1_data); end
    checks++;
    if (wb_err !== 1'b0) begin errors++; $display("FAIL x0_wb_err got %b exp 0", wb_err); end
  endtask

  task automatic test_raw_hazard();
    idle_a();
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd5;
    tick();
    issue_rd_en = 1'b0; rs1_used = 1'b1; rs1_addr = 5'd5;
    #1;
    checks++;
    if (busy_vec !== 32'h20) begin errors++; $display("FAIL raw_busy got %h exp 00000020", busy_vec); end
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %b exp 1", stall); end
    tick();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678;
    #1;
    checks++;
    if (stall !== !BYP) begin errors++; $display("FAIL raw_wb_stall got %b exp %b", stall, !BYP); end
    checks++;
    if (rs1_data !== (BYP ? 32'h12345678 : 32'h0)) begin
      errors++; $display("FAIL raw_wb_data got %h exp %h", rs1_data, BYP ? 32'h12345678 : 32'h0);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL raw_after_stall got %b exp 0", stall); end
    checks++;
    if (rs1_data !== 32'h12345678) begin errors++; $display("FAIL raw_after_data got %h exp 12345678", rs1_data); end
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL raw_after_busy got %h exp 0", busy_vec); end
    tick();
    idle_a();
  endtask

  task automatic test_same_cycle();
    idle_a();
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd7;
    tick();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5A5A5;
    #1;
    checks++;
    if (stall !== !BYP) begin errors++; $display("FAIL same_stall got %b exp %b", stall, !BYP); end
    tick();
    wb_valid = 1'b0; rs2_addr = 5'd7;
    #1;
    checks++;
    if (busy_vec !== (BYP ? 32'h80 : 32'h0)) begin
      errors++; $display("FAIL same_busy got %h exp %h", busy_vec, BYP ? 32'h80 : 32'h0);
    end
    checks++;
    if (rs2_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL same_data got %h exp a5a5a5a5", rs2_data); end
    checks++;
    if (wb_err !== 1'b0) begin errors++; $display("FAIL same_err got %b exp 0", wb_err); end
    checks++;
    if (stall !== BYP) begin errors++; $display("FAIL same_retry_stall got %b exp %b", stall, BYP); end
    tick();
    idle_a();
    checks++;
    if (busy_vec !== 32'h80) begin errors++; $display("FAIL same_final_busy got %h exp 00000080", busy_vec); end
  endtask

  task automatic test_wb_err();
    idle_a();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h1;
    tick();
    idle_a();
    rs1_addr = 5'd9;
    #1;
    checks++;
    if (rs1_data !== 32'h1) begin errors++; $display("FAIL err_data got %h exp 1", rs1_data); end
    checks++;
    if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", wb_err); end
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd10;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h5;
    tick();
    idle_a();
    checks++;
    if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", wb_err); end
    checks++;
    if (busy_vec !== 32'h80) begin errors++; $display("FAIL err_busy got %h exp 00000080", busy_vec); end
  endtask

  task automatic test_waw_reset();
    idle_a();
    issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5'd3;
    tick();
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got %b exp 1", stall); end
    tick();
    checks++;
    if (busy_vec !== 32'h88) begin errors++; $display("FAIL waw_busy got %h exp 00000088", busy_vec); end
    rs1_addr = 5'd9; rs2_addr = 5'd7;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_vec !== 32'h0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state got %h/%b exp 0/0", busy_vec, wb_err);
    end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got %b exp 0", stall); end
    checks++;
    if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
      errors++; $display("FAIL rst_mid_regs got %h/%h exp 0/0", rs1_data, rs2_data);
    end
    idle_a();
    tick();
    rst = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hCAFE0003;
    tick();
    idle_a();
    rs1_addr = 5'd3;
    #1;
    checks++;
    if (wb_err !== 1'b1) begin errors++; $display("FAIL stale_wb_err got %b exp 1", wb_err); end
    checks++;
    if (rs1_data !== 32'hCAFE0003) begin errors++; $display("FAIL stale_wb_data got %h exp cafe0003", rs1_data); end
  endtask

  task automatic test_random();
    idle_a();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
    m_busy = '0;
    m_err  = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] e1, e2;
      logic        eb1, eb2, ebd, est, acc;
      rs1_addr    = 5'($urandom_range(0, 7));
      rs2_addr    = 5'($urandom_range(0, 7));
      rs1_used    = 1'($urandom_range(0, 1));
      rs2_used    = 1'($urandom_range(0, 1));
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_rd_en = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      wb_valid    = ($urandom_range(0, 9) < 4);
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      // Mostly retire pending destinations so the pipeline keeps moving.
      if ((m_busy[7:0] != 8'h0) && ($urandom_range(0, 3) != 0)) begin
        for (int k = 0; k < 8; k++) begin
          if (m_busy[(int'(wb_rd) + k) % 8]) begin
            wb_rd = 5'((int'(wb_rd) + k) % 8);
            break;
          end
        end
      end
      #1;
      e1  = (rs1_addr == 0) ? 32'h0 : (BYP && wb_valid && wb_rd == rs1_addr) ? wb_data : m_reg[rs1_addr];
      e2  = (rs2_addr == 0) ? 32'h0 : (BYP && wb_valid && wb_rd == rs2_addr) ? wb_data : m_reg[rs2_addr];
      eb1 = m_busy[rs1_addr] && !(BYP && wb_valid && wb_rd == rs1_addr);
      eb2 = m_busy[rs2_addr] && !(BYP && wb_valid && wb_rd == rs2_addr);
      ebd = m_busy[issue_rd] && !(BYP && wb_valid && wb_rd == issue_rd);
      est = issue_valid && ((rs1_used && eb1) || (rs2_used && eb2) || (issue_rd_en && ebd));
      acc = issue_valid && !est;
      checks++;
      if (rs1_data !== e1 || rs2_data !== e2) begin
        errors++; $display("FAIL rnd_read cyc %0d got %h/%h exp %h/%h", n, rs1_data, rs2_data, e1, e2);
      end
      checks++;
      if (stall !== est) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", n, stall, est); end
      @(posedge clk);
      if (wb_valid && wb_rd != 0) begin
        if (!m_busy[wb_rd]) m_err = 1'b1;
        m_reg[wb_rd]  = wb_data;
        m_busy[wb_rd] = 1'b0;
      end
      if (acc && issue_rd_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      #1;
      checks++;
      if (busy_vec !== m_busy || wb_err !== m_err) begin
        errors++; $display("FAIL rnd_state cyc %0d got %h/%b exp %h/%b", n, busy_vec, wb_err, m_busy, m_err);
      end
    end
    idle_a();
  endtask

  task automatic test_param_sweep();
    idle_a();
    idle_b();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_issue_valid = 1'b1; b_issue_rd_en = 1'b1; b_issue_rd = 4'd0;
    tick();
    b_issue_rd_en = 1'b0; b_rs1_used = 1'b1; b_rs1_addr = 4'd0;
    #1;
    checks++;
    if (b_busy_vec !== 16'h0001) begin errors++; $display("FAIL p_busy got %h exp 0001", b_busy_vec); end
    checks++;
    if (b_stall !== 1'b1) begin errors++; $display("FAIL p_stall got %b exp 1", b_stall); end
    b_wb_valid = 1'b1; b_wb_rd = 4'd0; b_wb_data = 64'hFFFF_FFFF_0000_0001;
    #1;
    checks++;
    if (b_stall !== !BYP) begin errors++; $display("FAIL p_wb_stall got %b exp %b", b_stall, !BYP); end
    checks++;
    if (b_rs1_data !== (BYP ? 64'hFFFF_FFFF_0000_0001 : 64'h0)) begin
      errors++; $display("FAIL p_wb_data got %h exp %h", b_rs1_data, BYP ? 64'hFFFF_FFFF_0000_0001 : 64'h0);
    end
    tick();
    idle_b();
    b_rs2_addr = 4'd0;
    #1;
    checks++;
    if (b_rs1_data !== 64'hFFFF_FFFF_0000_0001 || b_rs2_data !== 64'hFFFF_FFFF_0000_0001) begin
      errors++; $display("FAIL p_x0_read got %h/%h exp ffffffff00000001", b_rs1_data, b_rs2_data);
    end
    checks++;
    if (b_busy_vec !== 16'h0 || b_wb_err !== 1'b0) begin
      errors++; $display("FAIL p_final got %h/%b exp 0000/0", b_busy_vec, b_wb_err);
    end
  endtask

  initial begin
    idle_a();
    idle_b();
    test_reset();
    test_raw_hazard();
    test_same_cycle();
    test_wb_err();
    test_waw_reset();
    test_random();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
